// File: rtl/hamming_receiver_pkg.sv
// Shared widths, FSM state type and bit-position mapping for the Hamming(11,7) receive path.
package hamming_receiver_pkg;

   localparam int CODE_W          = 11;
   localparam int DATA_W          = 7;
   localparam int SYN_W           = 4;
   localparam int BITCNT_W        = 4;
   localparam int MAX_CORRECTABLE = 11;

   typedef enum logic [1:0] {
      HUNT,
      SHIFT,
      DECODE
   } state_t;

   // code[k] is Hamming position k+1; payload d0..d6 sits at positions 3,5,6,7,9,10,11.
   function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
      return {code[10], code[9], code[8], code[6], code[5], code[4], code[2]};
   endfunction

endpackage

// File: rtl/hamming11_decoder.sv
// Combinational Hamming(11,7) single-error-correcting decoder.
module hamming11_decoder
   import hamming_receiver_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [DATA_W-1:0] data,
   output logic [SYN_W-1:0]  syndrome,
   output logic              corrected,
   output logic              uncorrectable
);

   logic [CODE_W-1:0] fixed;

   // NOTE: blocking assignments here on purpose; the syndrome accumulates across loop iterations.
   always_comb begin
      syndrome = '0;
      for (int k = 0; k < CODE_W; k++) begin
         if (code[k]) syndrome = syndrome ^ SYN_W'(k + 1);
      end

      fixed = code;
      for (int k = 0; k < CODE_W; k++) begin
         if (syndrome == SYN_W'(k + 1)) fixed[k] = ~code[k];
      end

      corrected     = (syndrome != '0) && (syndrome <= SYN_W'(MAX_CORRECTABLE));
      uncorrectable = (syndrome > SYN_W'(MAX_CORRECTABLE));
      data          = extract_data(fixed);
   end

endmodule

// File: rtl/hamming_receiver.sv
// Serial Hamming(11,7) receiver: SOF alignment, deserialisation, SEC decode and link counters.
module hamming_receiver
   import hamming_receiver_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_bit,
   input  logic              rx_valid,
   input  logic              rx_sof,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              err_corrected,
   output logic              err_uncorrectable,
   output logic [SYN_W-1:0]  syndrome,
   output logic [CNT_W-1:0]  word_count,
   output logic [CNT_W-1:0]  err_count
);

   state_t              state, state_next;
   // Only the first ten bits need storage; the eleventh is decoded straight off rx_bit.
   logic [CODE_W-2:0]   shreg, shreg_next;
   logic [BITCNT_W-1:0] bit_cnt, bit_cnt_next;
   logic                word_done;

   logic [CODE_W-1:0]   code_in;
   logic [DATA_W-1:0]   dec_data;
   logic [SYN_W-1:0]    dec_syn;
   logic                dec_corrected;
   logic                dec_uncorrectable;

   assign code_in = {shreg, rx_bit};

   hamming11_decoder u_decoder (
      .code          (code_in),
      .data          (dec_data),
      .syndrome      (dec_syn),
      .corrected     (dec_corrected),
      .uncorrectable (dec_uncorrectable)
   );

   // NOTE: every signal gets its default before the case so no latch can be inferred.
   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
      word_done    = 1'b0;

      case (state)
         HUNT: begin
            if (rx_valid && rx_sof) begin
               shreg_next   = {{(CODE_W-2){1'b0}}, rx_bit};
               bit_cnt_next = BITCNT_W'(1);
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            if (rx_valid && rx_sof) begin
               shreg_next   = {{(CODE_W-2){1'b0}}, rx_bit};
               bit_cnt_next = BITCNT_W'(1);
            end else if (rx_valid) begin
               shreg_next   = {shreg[CODE_W-3:0], rx_bit};
               bit_cnt_next = bit_cnt + BITCNT_W'(1);
               if (bit_cnt == BITCNT_W'(CODE_W - 1)) begin
                  word_done  = 1'b1;
                  state_next = DECODE;
               end
            end
         end
         DECODE: begin
            if (rx_valid && rx_sof) begin
               shreg_next   = {{(CODE_W-2){1'b0}}, rx_bit};
               bit_cnt_next = BITCNT_W'(1);
               state_next   = SHIFT;
            end else begin
               bit_cnt_next = '0;
               state_next   = HUNT;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HUNT;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_cnt <= bit_cnt_next;
      end
   end

   // Results are captured on the edge that accepts the 11th bit, so data_valid is high during DECODE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out          <= '0;
         data_valid        <= 1'b0;
         err_corrected     <= 1'b0;
         err_uncorrectable <= 1'b0;
         syndrome          <= '0;
         word_count        <= '0;
         err_count         <= '0;
      end else begin
         data_valid        <= word_done;
         err_corrected     <= word_done & dec_corrected;
         err_uncorrectable <= word_done & dec_uncorrectable;
         if (word_done) begin
            data_out <= dec_data;
            syndrome <= dec_syn;
            if (word_count != '1) word_count <= word_count + CNT_W'(1);
            if ((dec_syn != '0) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hamming_receiver.sv
// Randomised self-checking bench for hamming_receiver against a bit-list reference model.
module tb_hamming_receiver;

   localparam int CNT_W = 6;
   localparam int SAT   = (1 << CNT_W) - 1;
   localparam int DPOS [7] = '{3, 5, 6, 7, 9, 10, 11};

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             rx_bit = 1'b0;
   logic             rx_valid = 1'b0;
   logic             rx_sof = 1'b0;
   logic [6:0]       data_out;
   logic             data_valid;
   logic             err_corrected;
   logic             err_uncorrectable;
   logic [3:0]       syndrome;
   logic [CNT_W-1:0] word_count;
   logic [CNT_W-1:0] err_count;

   hamming_receiver #(.CNT_W(CNT_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .rx_bit            (rx_bit),
      .rx_valid          (rx_valid),
      .rx_sof            (rx_sof),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .err_corrected     (err_corrected),
      .err_uncorrectable (err_uncorrectable),
      .syndrome          (syndrome),
      .word_count        (word_count),
      .err_count         (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [6:0] d;
      logic [3:0] s;
      bit         corr;
      bit         unc;
      int         wc;
      int         ec;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   cur[$];
   bit   collecting = 1'b0;
   int   m_wc = 0;
   int   m_ec = 0;

   function automatic logic [10:0] encode(input logic [6:0] d);
      logic [10:0] c;
      logic        par;
      c = '0;
      for (int i = 0; i < 7; i++) c[DPOS[i]-1] = d[i];
      for (int p = 1; p <= 8; p = p * 2) begin
         par = 1'b0;
         for (int j = 1; j <= 11; j++) if (((j & p) != 0) && (j != p)) par ^= c[j-1];
         c[p-1] = par;
      end
      return c;
   endfunction

   // Reference: any sof restarts the bit list; other bits only count while collecting.
   task automatic model_strobe(input logic b, input logic sof);
      logic [10:0] c;
      int          s;
      exp_t        e;
      if (sof) begin
         cur.delete();
         cur.push_back(b);
         collecting = 1'b1;
      end else if (collecting) begin
         cur.push_back(b);
      end
      if (collecting && cur.size() == 11) begin
         for (int i = 0; i < 11; i++) c[10-i] = cur[i];
         s = 0;
         for (int j = 1; j <= 11; j++) if (c[j-1]) s ^= j;
         e.s    = 4'(s);
         e.corr = (s >= 1 && s <= 11);
         e.unc  = (s >= 12);
         if (e.corr) c[s-1] = ~c[s-1];
         for (int i = 0; i < 7; i++) e.d[i] = c[DPOS[i]-1];
         if (m_wc < SAT) m_wc++;
         if (s != 0 && m_ec < SAT) m_ec++;
         e.wc  = m_wc;
         e.ec  = m_ec;
         e.due = cyc;
         exp_q.push_back(e);
         collecting = 1'b0;
         cur.delete();
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cur.delete();
      collecting = 1'b0;
      m_wc = 0;
      m_ec = 0;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", data_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("latency", cyc, mon_e.due);
               check("data_out", data_out, mon_e.d);
               check("syndrome", syndrome, mon_e.s);
               check("err_corrected", err_corrected, mon_e.corr);
               check("err_uncorrectable", err_uncorrectable, mon_e.unc);
               check("word_count", word_count, mon_e.wc);
               check("err_count", err_count, mon_e.ec);
            end
         end else begin
            check("flags_idle", {err_corrected, err_uncorrectable}, 0);
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
               check("missed_valid", data_valid, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic strobe(input logic b, input logic sof);
      rx_valid = 1'b1;
      rx_bit   = b;
      rx_sof   = sof;
      @(posedge clk);
      #1;
      model_strobe(b, sof);
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_bit   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [10:0] code, input int maxgap);
      for (int i = 10; i >= 0; i--) begin
         strobe(code[i], i == 10);
         if (i > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data_out"}, data_out, 0);
      check({tag, "_valid_flags"}, {data_valid, err_corrected, err_uncorrectable}, 0);
      check({tag, "_syndrome"}, syndrome, 0);
      check({tag, "_counts"}, {word_count, err_count}, 0);
   endtask

   task automatic check_held(input string tag, input logic [6:0] d, input logic [3:0] s,
                             input int wc, input int ec);
      check({tag, "_data_out"}, data_out, d);
      check({tag, "_syndrome"}, syndrome, s);
      check({tag, "_word_count"}, word_count, wc);
      check({tag, "_err_count"}, err_count, ec);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] code;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;
      idle(2);

      send_word(11'h54E, 0);
      idle(3);
      check_held("clean", 7'h59, 4'd0, 1, 0);

      send_word(11'h56E, 1);
      idle(3);
      check_held("single", 7'h59, 4'd6, 2, 1);

      send_word(11'h5C6, 2);
      idle(3);
      check_held("double", 7'h59, 4'd12, 3, 2);

      strobe(1'b1, 1'b1);
      repeat (4) strobe(1'($urandom), 1'b0);
      send_word(11'h54E, 0);
      idle(3);
      check_held("resync", 7'h59, 4'd0, 4, 2);

      repeat (3) strobe(1'($urandom), 1'b0);
      send_word(11'h54E, 2);
      send_word(11'h56E, 2);
      idle(3);
      check_held("b2b", 7'h59, 4'd6, 6, 3);

      send_word(11'h54E, 0);
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
      idle(3);
      check_held("decode_ignore", 7'h59, 4'd0, 7, 3);

      for (int w = 0; w < 120; w++) begin
         if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) strobe(1'($urandom), 1'b0);
         if ($urandom_range(0, 7) == 0) begin
            strobe(1'($urandom), 1'b1);
            repeat ($urandom_range(0, 9)) strobe(1'($urandom), 1'b0);
         end
         code = encode(7'($urandom));
         repeat ($urandom_range(0, 3)) code ^= (11'b1 << $urandom_range(0, 10));
         send_word(code, 2);
         idle($urandom_range(0, 2));
      end
      idle(3);

      reset = 1'b0;
      model_reset();
      idle(2);
      reset = 1'b1;
      idle(1);

      for (int w = 0; w < SAT; w++) begin
         code = encode(7'($urandom)) ^ (11'b1 << $urandom_range(0, 10));
         send_word(code, 0);
      end
      idle(3);
      check("sat_word_count", word_count, SAT);
      check("sat_err_count", err_count, SAT);
      repeat (3) send_word(encode(7'($urandom)) ^ 11'h001, 0);
      idle(3);
      check("hold_word_count", word_count, SAT);
      check("hold_err_count", err_count, SAT);

      strobe(1'b1, 1'b1);
      repeat (3) strobe(1'($urandom), 1'b0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_zero("async_reset");
      idle(2);
      reset = 1'b1;
      idle(1);
      send_word(11'h54E, 1);
      idle(3);
      check_held("post_reset", 7'h59, 4'd0, 1, 0);

      check("pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
